// File: rtl/tt_sweep_pkg.sv
// Shared types and defaults for the truth-table sweep stage.
// State encoding is fixed so board-level probes can decode it directly.
package tt_sweep_pkg;

    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tt_sweep_if.sv
// Handshake/result bundle between the sweep stage and its controller/DUT.
interface tt_sweep_if #(
    parameter int N_IN = 3
);
    localparam int W = 2 ** N_IN;

    logic            start;
    logic [W-1:0]    exp_tt;
    logic            dut_y;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [W-1:0]    obs_tt;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err;

    modport master (
        output start, exp_tt, dut_y,
        input  dut_in, busy, done, pass, obs_tt, err_cnt, first_err
    );

    modport slave (
        input  start, exp_tt, dut_y,
        output dut_in, busy, done, pass, obs_tt, err_cnt, first_err
    );

endinterface

// File: rtl/tt_settle_timer.sv
// Settle-time down-counter: load restarts it at SETTLE-1, expire flags terminal count.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == 4'd0);

endmodule

// File: rtl/tt_sweep.sv
// Exhaustive stimulus stage: walks dut_in through every code, captures dut_y per code
// into a truth table and scores it against the expected table latched at start.
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    tt_sweep_if.slave  sw
);

    localparam int W = 2 ** N_IN;
    localparam logic [N_IN:0] ERR_ONE = 1;

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [W-1:0]    exp_q, exp_d;
    logic [W-1:0]    obs_q, obs_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ferr_q, ferr_d;
    logic            pass_q, pass_d;
    logic            timer_load;
    logic            timer_expire;

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        exp_d      = exp_q;
        obs_d      = obs_q;
        err_d      = err_q;
        ferr_d     = ferr_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (sw.start) begin
                    state_d    = S_SETTLE;
                    idx_d      = '0;
                    exp_d      = sw.exp_tt;
                    obs_d      = '0;
                    err_d      = '0;
                    ferr_d     = '0;
                    pass_d     = 1'b0;
                    timer_load = 1'b1;
                end
            end
            S_SETTLE: begin
                if (timer_expire) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                obs_d[idx_q] = sw.dut_y;
                if (sw.dut_y != exp_q[idx_q]) begin
                    err_d = err_q + ERR_ONE;
                    if (err_q == '0) begin
                        ferr_d = idx_q;
                    end
                end
                // Terminal compare on all-ones keeps idx from wrapping back to 0 in DONE.
                if (idx_q == '1) begin
                    state_d = S_DONE;
                    pass_d  = (obs_d == exp_q);
                end else begin
                    state_d    = S_SETTLE;
                    idx_d      = idx_q + 1'b1;
                    timer_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            obs_q   <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            obs_q   <= obs_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
        end
    end

    assign sw.dut_in    = idx_q;
    assign sw.busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign sw.done      = (state_q == S_DONE);
    assign sw.pass      = pass_q;
    assign sw.obs_tt    = obs_q;
    assign sw.err_cnt   = err_q;
    assign sw.first_err = ferr_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: table-driven stub DUT, sweep-level reference model, per-cycle compare.
module tb_tt_sweep;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int W      = 1 << N_IN;
    localparam int VLEN   = SETTLE + 1;
    localparam int SWEEP  = W * VLEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_sweep_if #(.N_IN(N_IN)) sw_if ();

    tt_sweep #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw_if)
    );

    logic [W-1:0] stub_tbl;
    assign sw_if.dut_y = stub_tbl[sw_if.dut_in];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stub functions over {a,b,d}; index i = a*4 + b*2 + d.
    function automatic logic [W-1:0] tt_of(input int mode);
        logic [W-1:0] t;
        logic a, b, d;
        t = '0;
        for (int i = 0; i < W; i++) begin
            a = i[2]; b = i[1]; d = i[0];
            case (mode)
                0: t[i] = a & d;
                1: t[i] = 1'b1;
                default: t[i] = (a | d) & (~b | d);
            endcase
        end
        return t;
    endfunction

    // Reference model: a sweep is just "edges since acceptance"; vector v is captured
    // at edge 3v+3, done after SWEEP edges.
    bit           m_busy, m_done;
    int           m_k;
    logic [W-1:0] m_exp, m_tt;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_k = 0; m_exp = '0; m_tt = '0;
        end else if (!m_busy && sw_if.start) begin
            m_busy = 1; m_done = 0; m_k = 0; m_exp = sw_if.exp_tt; m_tt = stub_tbl;
        end else if (m_busy) begin
            m_k++;
            if (m_k == SWEEP) begin
                m_busy = 0; m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        int nv, ec, fe, din;
        logic [W-1:0] mask, mis;
        if (chk_en) begin
            if (m_busy) begin
                nv = m_k / VLEN; din = m_k / VLEN;
            end else if (m_done) begin
                nv = W; din = W - 1;
            end else begin
                nv = 0; din = 0;
            end
            mask = (nv >= W) ? '1 : W'((1 << nv) - 1);
            mis  = (m_tt ^ m_exp) & mask;
            ec   = $countones(mis);
            fe   = 0;
            for (int i = W - 1; i >= 0; i--) if (mis[i]) fe = i;
            chk("dut_in",    32'(sw_if.dut_in),    32'(din));
            chk("busy",      32'(sw_if.busy),      32'(m_busy));
            chk("done",      32'(sw_if.done),      32'(m_done));
            chk("obs_tt",    32'(sw_if.obs_tt),    32'(m_tt & mask));
            chk("err_cnt",   32'(sw_if.err_cnt),   32'(ec));
            chk("first_err", 32'(sw_if.first_err), 32'(fe));
            chk("pass",      32'(sw_if.pass),      32'(m_done && ec == 0));
        end
    end

    task automatic start_and_wait(input logic [W-1:0] exp, output int n);
        sw_if.exp_tt = exp;
        sw_if.start  = 1'b1;
        @(negedge clk);
        sw_if.start = 1'b0;
        n = 0;
        while (!sw_if.done && n < SWEEP + 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_results(input string tag, input logic [W-1:0] obs, input int pass,
                               input int ec, input int fe);
        chk({tag, "_obs"},   32'(sw_if.obs_tt),    32'(obs));
        chk({tag, "_pass"},  32'(sw_if.pass),      32'(pass));
        chk({tag, "_err"},   32'(sw_if.err_cnt),   32'(ec));
        chk({tag, "_ferr"},  32'(sw_if.first_err), 32'(fe));
    endtask

    initial begin
        int n;
        sw_if.start  = 1'b0;
        sw_if.exp_tt = '0;
        stub_tbl     = tt_of(0);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_done", 32'(sw_if.done), 32'd0);
        chk("rst_obs",  32'(sw_if.obs_tt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        chk("tt_and",   32'(tt_of(0)), 32'hA0);
        chk("tt_one",   32'(tt_of(1)), 32'hFF);
        chk("tt_posdf", 32'(tt_of(2)), 32'hBA);

        // 1: matching table
        start_and_wait(8'hA0, n);
        chk("t1_latency", 32'(n), 32'(SWEEP));
        chk_results("t1", 8'hA0, 1, 0, 0);
        chk("t1_din", 32'(sw_if.dut_in), 32'd7);

        // 2: single mismatch at index 0
        start_and_wait(8'hA1, n);
        chk("t2_latency", 32'(n), 32'(SWEEP));
        chk_results("t2", 8'hA0, 0, 1, 0);

        // 3: every entry wrong
        @(negedge clk);
        stub_tbl = tt_of(1);
        start_and_wait(8'h00, n);
        chk_results("t3", 8'hFF, 0, 8, 0);

        // 4: reset mid-sweep while dut_in==4
        stub_tbl = tt_of(0);
        sw_if.exp_tt = 8'hA0;
        sw_if.start  = 1'b1;
        @(negedge clk);
        sw_if.start = 1'b0;
        n = 0;
        while (sw_if.dut_in != 3'd4 && n < SWEEP) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reach4", 32'(sw_if.dut_in), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_busy", 32'(sw_if.busy), 32'd0);
        chk("t4_din",  32'(sw_if.dut_in), 32'd0);
        chk_results("t4r", 8'h00, 0, 0, 0);
        start_and_wait(8'hA0, n);
        chk("t4_latency", 32'(n), 32'(SWEEP));
        chk_results("t4", 8'hA0, 1, 0, 0);

        // 5: restart attempts and exp_tt changes while busy are ignored
        sw_if.exp_tt = 8'hA0;
        sw_if.start  = 1'b1;
        @(negedge clk);
        sw_if.start = 1'b0;
        n = 0;
        while (!sw_if.done && n < SWEEP + 10) begin
            @(negedge clk);
            n++;
            sw_if.start  = (n == 5 || n == 10);
            sw_if.exp_tt = W'($urandom);
        end
        sw_if.start = 1'b0;
        chk("t5_latency", 32'(n), 32'(SWEEP));
        chk_results("t5", 8'hA0, 1, 0, 0);

        // 6: POS function, start held high in DONE for back-to-back sweeps
        stub_tbl = tt_of(2);
        start_and_wait(8'hBA, n);
        chk_results("t6a", 8'hBA, 1, 0, 0);
        sw_if.start = 1'b1;
        @(negedge clk);
        chk("t6_restart_done", 32'(sw_if.done), 32'd0);
        chk("t6_restart_busy", 32'(sw_if.busy), 32'd1);
        n = 0;
        while (!sw_if.done && n < SWEEP + 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_latency", 32'(n), 32'(SWEEP));
        chk_results("t6b", 8'hBA, 1, 0, 0);
        sw_if.start = 1'b0;
        @(negedge clk);

        // Randomized sweeps, spurious starts, exp churn and occasional mid-sweep reset
        for (int it = 0; it < 24; it++) begin
            stub_tbl     = W'($urandom);
            sw_if.exp_tt = ($urandom_range(0, 2) == 0) ? stub_tbl : (stub_tbl ^ W'($urandom));
            sw_if.start  = 1'b1;
            @(negedge clk);
            sw_if.start = 1'b0;
            n = 0;
            while (!sw_if.done && n < SWEEP + 10) begin
                @(negedge clk);
                n++;
                sw_if.start  = ($urandom_range(0, 7) == 0);
                sw_if.exp_tt = W'($urandom);
                if (it % 6 == 5 && n == int'($urandom_range(1, SWEEP - 2))) begin
                    sw_if.start = 1'b0;
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    break;
                end
            end
            sw_if.start = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
